// File: rtl/qnigma_pkg.sv
// Shared TCP types and constants for the qnigma stack: option kinds, option
// lengths, window-scale limits and the parsed-options bundle.
package qnigma_pkg;

    typedef logic [3:0] tcp_scl_t;

    typedef enum logic [7:0] {
        TCP_OPT_EOL       = 8'd0,
        TCP_OPT_NOP       = 8'd1,
        TCP_OPT_MSS       = 8'd2,
        TCP_OPT_WS        = 8'd3,
        TCP_OPT_SACK_PERM = 8'd4,
        TCP_OPT_TS        = 8'd8
    } tcp_opt_kind_t;

    localparam logic [7:0] TCP_OPT_LEN_MSS = 8'd4;
    localparam logic [7:0] TCP_OPT_LEN_WS  = 8'd3;
    localparam logic [7:0] TCP_OPT_LEN_TS  = 8'd10;
    localparam int         TCP_MAX_SCL     = 14;

    typedef struct packed {
        logic        mss_pres;
        logic [15:0] mss;
        logic        ws_pres;
        tcp_scl_t    scl;
        logic        sack_perm;
        logic        ts_pres;
        logic [31:0] ts_val;
        logic [31:0] ts_ecr;
    } tcp_opt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KIND,
        ST_LEN,
        ST_DATA,
        ST_PAD
    } opt_state_t;

    function automatic tcp_scl_t clamp_scl(input logic [7:0] shift, input int max_scl);
        if (int'(shift) > max_scl) return tcp_scl_t'(max_scl);
        return shift[3:0];
    endfunction

endpackage

// File: rtl/qnigma_tcp_opt_parse.sv
// Byte-serial TCP options parser: extracts MSS, window scale, SACK-permitted and
// timestamps into shadow registers and publishes them atomically with done.
module qnigma_tcp_opt_parse
    import qnigma_pkg::*;
#(
    parameter int MAX_OPT_LEN = 40,
    parameter int MAX_SCL     = TCP_MAX_SCL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt,
    input  logic        val,
    input  logic [7:0]  dat,
    input  logic        last,
    input  logic        syn,
    output logic        done,
    output logic        err,
    output logic        set_scl,
    output tcp_scl_t    scl,
    output logic        mss_pres,
    output logic [15:0] mss,
    output logic        sack_perm,
    output logic        ts_pres,
    output logic [31:0] ts_val,
    output logic [31:0] ts_ecr
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_OPT_LEN);

    opt_state_t  state, st_n;
    logic [7:0]  kind, kind_n;
    logic [7:0]  len, len_n;
    logic [7:0]  rem, rem_n;
    logic [7:0]  cnt, cnt_n;
    logic [31:0] acc, acc_n;
    logic        syn_q, syn_n;
    tcp_opt_t    sh, sh_n;
    logic        sh_err, err_n;
    logic        fin;

    function automatic opt_state_t kind_next(input logic [7:0] k);
        case (k)
            TCP_OPT_EOL: return ST_PAD;
            TCP_OPT_NOP: return ST_KIND;
            default:     return ST_LEN;
        endcase
    endfunction

    // NOTE: every comb output gets a default first so no latch is inferred;
    // blocking '=' is correct here because later lines read earlier results.
    always_comb begin
        st_n   = state;
        kind_n = kind;
        len_n  = len;
        rem_n  = rem;
        cnt_n  = cnt;
        acc_n  = acc;
        syn_n  = syn_q;
        sh_n   = sh;
        err_n  = sh_err;
        fin    = 1'b0;

        if (val && strt) begin
            sh_n   = '0;
            err_n  = 1'b0;
            cnt_n  = 8'd1;
            syn_n  = syn;
            kind_n = dat;
            st_n   = kind_next(dat);
        end else if (val && state != ST_IDLE) begin
            if (cnt == MAX_LEN_B) begin
                err_n = 1'b1;
                st_n  = ST_PAD;
            end else begin
                cnt_n = cnt + 8'd1;
                case (state)
                    ST_KIND: begin
                        kind_n = dat;
                        st_n   = kind_next(dat);
                    end
                    ST_LEN: begin
                        len_n = dat;
                        if (dat < 8'd2) begin
                            err_n = 1'b1;
                            st_n  = ST_PAD;
                        end else if (dat == 8'd2) begin
                            if (kind == TCP_OPT_SACK_PERM) sh_n.sack_perm = 1'b1;
                            st_n = ST_KIND;
                        end else begin
                            rem_n = dat - 8'd2;
                            st_n  = ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        acc_n = {acc[23:0], dat};
                        rem_n = rem - 8'd1;
                        // First four timestamp bytes are TSval; the accumulator then refills with TSecr.
                        if (kind == TCP_OPT_TS && len == TCP_OPT_LEN_TS && rem == 8'd5)
                            sh_n.ts_val = acc_n;
                        if (rem == 8'd1) begin
                            st_n = ST_KIND;
                            if (kind == TCP_OPT_MSS && len == TCP_OPT_LEN_MSS) begin
                                sh_n.mss_pres = 1'b1;
                                sh_n.mss      = acc_n[15:0];
                            end
                            if (kind == TCP_OPT_WS && len == TCP_OPT_LEN_WS) begin
                                sh_n.ws_pres = 1'b1;
                                sh_n.scl     = clamp_scl(dat, MAX_SCL);
                            end
                            if (kind == TCP_OPT_TS && len == TCP_OPT_LEN_TS) begin
                                sh_n.ts_pres = 1'b1;
                                sh_n.ts_ecr  = acc_n;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Ending with an option still open (waiting for length or data) is a truncation.
        if (val && last && (strt || state != ST_IDLE)) begin
            fin = 1'b1;
            if (st_n == ST_LEN || st_n == ST_DATA) err_n = 1'b1;
            st_n = ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            kind      <= '0;
            len       <= '0;
            rem       <= '0;
            cnt       <= '0;
            acc       <= '0;
            syn_q     <= 1'b0;
            sh        <= '0;
            sh_err    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            set_scl   <= 1'b0;
            scl       <= '0;
            mss_pres  <= 1'b0;
            mss       <= '0;
            sack_perm <= 1'b0;
            ts_pres   <= 1'b0;
            ts_val    <= '0;
            ts_ecr    <= '0;
        end else begin
            state  <= st_n;
            kind   <= kind_n;
            len    <= len_n;
            rem    <= rem_n;
            cnt    <= cnt_n;
            acc    <= acc_n;
            syn_q  <= syn_n;
            sh     <= sh_n;
            sh_err <= err_n;
            done   <= fin;
            if (fin) begin
                err       <= err_n;
                set_scl   <= syn_n && !err_n;
                scl       <= sh_n.scl;
                mss_pres  <= sh_n.mss_pres;
                mss       <= sh_n.mss;
                sack_perm <= sh_n.sack_perm;
                ts_pres   <= sh_n.ts_pres;
                ts_val    <= sh_n.ts_val;
                ts_ecr    <= sh_n.ts_ecr;
            end else begin
                set_scl <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qnigma_tcp_opt_parse.sv
// Directed self-checking bench for qnigma_tcp_opt_parse: hand-computed option
// segments covering normal parsing, clamping, errors, abort and reset.
module tb_qnigma_tcp_opt_parse;
    import qnigma_pkg::*;

    logic        clk, rst_n, strt, val, last, syn;
    logic [7:0]  dat;
    logic        done, err, set_scl, mss_pres, sack_perm, ts_pres;
    tcp_scl_t    scl;
    logic [15:0] mss;
    logic [31:0] ts_val, ts_ecr;

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [7:0] seg[$];

    qnigma_tcp_opt_parse dut (
        .clk(clk), .rst_n(rst_n), .strt(strt), .val(val), .dat(dat), .last(last),
        .syn(syn), .done(done), .err(err), .set_scl(set_scl), .scl(scl),
        .mss_pres(mss_pres), .mss(mss), .sack_perm(sack_perm), .ts_pres(ts_pres),
        .ts_val(ts_val), .ts_ecr(ts_ecr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    // Called at a negedge; returns at the next negedge, after the byte was sampled.
    task automatic drive(input logic [7:0] d, input logic s, input logic l, input logic y);
        val = 1'b1; dat = d; strt = s; last = l; syn = y;
        @(negedge clk);
        val = 1'b0; strt = 1'b0; last = 1'b0; syn = 1'b0; dat = 8'h00;
    endtask

    task automatic send_seg(input logic y, input int gap);
        for (int i = 0; i < seg.size(); i++) begin
            drive(seg[i], i == 0, i == seg.size() - 1, y);
            if (i != seg.size() - 1) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; strt = 1'b0; val = 1'b0; last = 1'b0; syn = 1'b0; dat = 8'h00;
        repeat (2) @(negedge clk);
        n_assert++;
        if ({done, err, set_scl, scl, mss_pres, mss, sack_perm, ts_pres, ts_val, ts_ecr} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got nonzero outputs, want all 0");
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_assert++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
    endtask

    task automatic test_mss_ws(input int gap, input string tag);
        seg = '{8'h02, 8'h04, 8'h05, 8'hB4, 8'h01, 8'h03, 8'h03, 8'h07};
        send_seg(1'b1, gap);
        n_assert += 6;
        if (done !== 1'b1) begin n_fail++; $display("FAIL %s done: got %0b want 1", tag, done); end
        if (mss_pres !== 1'b1) begin n_fail++; $display("FAIL %s mss_pres: got %0b want 1", tag, mss_pres); end
        if (mss !== 16'h05B4) begin n_fail++; $display("FAIL %s mss: got %h want 05b4", tag, mss); end
        if (scl !== 4'd7) begin n_fail++; $display("FAIL %s scl: got %0d want 7", tag, scl); end
        if (set_scl !== 1'b1) begin n_fail++; $display("FAIL %s set_scl: got %0b want 1", tag, set_scl); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL %s err: got %0b want 0", tag, err); end
        @(negedge clk);
        n_assert += 3;
        if (done !== 1'b0) begin n_fail++; $display("FAIL %s done_pulse: got %0b want 0", tag, done); end
        if (set_scl !== 1'b0) begin n_fail++; $display("FAIL %s set_scl_pulse: got %0b want 0", tag, set_scl); end
        if (mss !== 16'h05B4) begin n_fail++; $display("FAIL %s mss_hold: got %h want 05b4", tag, mss); end
    endtask

    task automatic test_ws_clamp();
        seg = '{8'h03, 8'h03, 8'h0F};
        send_seg(1'b1, 0);
        n_assert += 2;
        if (scl !== 4'd14) begin n_fail++; $display("FAIL ws_clamp scl: got %0d want 14", scl); end
        if (set_scl !== 1'b1) begin n_fail++; $display("FAIL ws_clamp set_scl: got %0b want 1", set_scl); end
        seg = '{8'h02, 8'h04, 8'h05, 8'hB4};
        send_seg(1'b1, 0);
        n_assert += 3;
        if (scl !== 4'd0) begin n_fail++; $display("FAIL ws_absent scl: got %0d want 0", scl); end
        if (set_scl !== 1'b1) begin n_fail++; $display("FAIL ws_absent set_scl: got %0b want 1", set_scl); end
        if (mss_pres !== 1'b1) begin n_fail++; $display("FAIL ws_absent mss_pres: got %0b want 1", mss_pres); end
    endtask

    task automatic test_ts();
        seg = '{8'h01, 8'h01, 8'h08, 8'h0A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_seg(1'b0, 0);
        n_assert += 6;
        if (ts_pres !== 1'b1) begin n_fail++; $display("FAIL ts ts_pres: got %0b want 1", ts_pres); end
        if (ts_val !== 32'h11223344) begin n_fail++; $display("FAIL ts ts_val: got %h want 11223344", ts_val); end
        if (ts_ecr !== 32'h55667788) begin n_fail++; $display("FAIL ts ts_ecr: got %h want 55667788", ts_ecr); end
        if (set_scl !== 1'b0) begin n_fail++; $display("FAIL ts set_scl: got %0b want 0", set_scl); end
        if (mss_pres !== 1'b0) begin n_fail++; $display("FAIL ts mss_pres: got %0b want 0", mss_pres); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL ts err: got %0b want 0", err); end
    endtask

    task automatic test_errors();
        seg = '{8'h02, 8'h04, 8'h05};
        send_seg(1'b1, 0);
        n_assert += 4;
        if (done !== 1'b1) begin n_fail++; $display("FAIL trunc done: got %0b want 1", done); end
        if (err !== 1'b1) begin n_fail++; $display("FAIL trunc err: got %0b want 1", err); end
        if (mss_pres !== 1'b0) begin n_fail++; $display("FAIL trunc mss_pres: got %0b want 0", mss_pres); end
        if (set_scl !== 1'b0) begin n_fail++; $display("FAIL trunc set_scl: got %0b want 0", set_scl); end
        seg = '{8'h03, 8'h01, 8'h00};
        send_seg(1'b1, 0);
        n_assert += 2;
        if (err !== 1'b1) begin n_fail++; $display("FAIL badlen err: got %0b want 1", err); end
        if (set_scl !== 1'b0) begin n_fail++; $display("FAIL badlen set_scl: got %0b want 0", set_scl); end
        seg.delete();
        for (int i = 0; i < 40; i++) seg.push_back(8'h01);
        send_seg(1'b1, 0);
        n_assert += 2;
        if (err !== 1'b0) begin n_fail++; $display("FAIL len40 err: got %0b want 0", err); end
        if (set_scl !== 1'b1) begin n_fail++; $display("FAIL len40 set_scl: got %0b want 1", set_scl); end
        seg.push_back(8'h01);
        send_seg(1'b1, 0);
        n_assert += 2;
        if (err !== 1'b1) begin n_fail++; $display("FAIL len41 err: got %0b want 1", err); end
        if (done !== 1'b1) begin n_fail++; $display("FAIL len41 done: got %0b want 1", done); end
    endtask

    task automatic test_eol_unknown();
        seg = '{8'h00, 8'h03, 8'h03, 8'h09};
        send_seg(1'b1, 0);
        n_assert += 3;
        if (err !== 1'b0) begin n_fail++; $display("FAIL eol err: got %0b want 0", err); end
        if (scl !== 4'd0) begin n_fail++; $display("FAIL eol scl: got %0d want 0", scl); end
        if (set_scl !== 1'b1) begin n_fail++; $display("FAIL eol set_scl: got %0b want 1", set_scl); end
        seg = '{8'h1E, 8'h06, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h04, 8'h02};
        send_seg(1'b0, 0);
        n_assert += 3;
        if (sack_perm !== 1'b1) begin n_fail++; $display("FAIL unknown sack_perm: got %0b want 1", sack_perm); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL unknown err: got %0b want 0", err); end
        if (mss_pres !== 1'b0) begin n_fail++; $display("FAIL unknown mss_pres: got %0b want 0", mss_pres); end
    endtask

    task automatic test_abort();
        int base;
        base = done_cnt;
        drive(8'h08, 1'b1, 1'b0, 1'b0);
        drive(8'h0A, 1'b0, 1'b0, 1'b0);
        drive(8'h11, 1'b0, 1'b0, 1'b0);
        seg = '{8'h02, 8'h04, 8'h12, 8'h34};
        send_seg(1'b0, 0);
        n_assert += 4;
        if (done_cnt - base !== 1) begin n_fail++; $display("FAIL abort done_count: got %0d want 1", done_cnt - base); end
        if (mss !== 16'h1234) begin n_fail++; $display("FAIL abort mss: got %h want 1234", mss); end
        if (ts_pres !== 1'b0) begin n_fail++; $display("FAIL abort ts_pres: got %0b want 0", ts_pres); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL abort err: got %0b want 0", err); end
    endtask

    task automatic test_reset_mid();
        int base;
        drive(8'h08, 1'b1, 1'b0, 1'b1);
        drive(8'h0A, 1'b0, 1'b0, 1'b1);
        drive(8'h11, 1'b0, 1'b0, 1'b1);
        drive(8'h22, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        n_assert++;
        if ({done, err, set_scl, scl, mss_pres, mss, sack_perm, ts_pres, ts_val, ts_ecr} !== '0) begin
            n_fail++; $display("FAIL midrst_outputs: got nonzero outputs, want all 0");
        end
        @(negedge clk);
        rst_n = 1'b1;
        base = done_cnt;
        drive(8'h33, 1'b0, 1'b1, 1'b0);
        val = 1'b0; strt = 1'b1; last = 1'b1; dat = 8'h02;
        @(negedge clk);
        strt = 1'b0; last = 1'b0; dat = 8'h00;
        repeat (3) @(negedge clk);
        n_assert += 2;
        if (done_cnt !== base) begin n_fail++; $display("FAIL midrst_nodone: got %0d pulses want 0", done_cnt - base); end
        if (mss_pres !== 1'b0) begin n_fail++; $display("FAIL midrst_mss_pres: got %0b want 0", mss_pres); end
    endtask

    initial begin
        test_reset();
        test_mss_ws(0, "mss_ws");
        test_ws_clamp();
        test_ts();
        test_errors();
        test_eol_unknown();
        test_abort();
        test_mss_ws(3, "gaps");
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
